// File: rtl/median_matrix_3x3.sv
// 3x3 neighbourhood builder for a raster-scanned grey stream.
// Two line buffers hold the previous two lines. A two-stage pipeline reads
// the buffers, shifts the window columns, and zero-pads any position that
// lies outside the image.
module median_matrix_3x3 #(
    parameter int IMG_WIDTH = 640,
    parameter int DW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vs,
    input  logic          i_de,
    input  logic [DW-1:0] i_data,
    output logic          o_vs,
    output logic          o_de,
    output logic [DW-1:0] o_p11,
    output logic [DW-1:0] o_p12,
    output logic [DW-1:0] o_p13,
    output logic [DW-1:0] o_p21,
    output logic [DW-1:0] o_p22,
    output logic [DW-1:0] o_p23,
    output logic [DW-1:0] o_p31,
    output logic [DW-1:0] o_p32,
    output logic [DW-1:0] o_p33
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

    // Position tracking
    logic          vs_q;
    logic          vs_rise;
    logic [CW-1:0] col_q, col_d, pos_col;
    logic [1:0]    row_q, row_d, pos_row;

    // Line buffers: A holds row r-1 and B holds row r-2
    logic [DW-1:0] line_a [IMG_WIDTH];
    logic [DW-1:0] line_b [IMG_WIDTH];
    logic [DW-1:0] a_rd_q;
    logic [DW-1:0] b_rd_q;

    // Stage 1 captures the newest pixel and its position
    logic          s1_de_q;
    logic [CW-1:0] s1_col_q;
    logic [1:0]    s1_row_q;
    logic [DW-1:0] s1_pix_q;

    // Stage 2 holds the window and the padding masks
    logic [DW-1:0]   col_new [3];
    logic [2:0]      row_ok;
    logic [2:0]      col_ok;
    logic [3*DW-1:0] row_win [3];
    logic            o_vs_q;
    logic            o_de_q;

    // The frame start clears the position for this very pixel, so it lands on (0,0)
    assign vs_rise = i_vs & ~vs_q;
    assign pos_col = vs_rise ? '0 : col_q;
    assign pos_row = vs_rise ? 2'd0 : row_q;

    // Next position: the column wraps at the line end and the row saturates at 2
    always_comb begin
        col_d = pos_col;
        row_d = pos_row;
        if (i_de) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                if (pos_row != 2'd2) begin
                    row_d = pos_row + 2'd1;
                end
            end else begin
                col_d = pos_col + 1'b1;
            end
        end
    end

    // Position registers and the frame-sync history
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q  <= 1'b0;
            col_q <= '0;
            row_q <= 2'd0;
        end else begin
            vs_q  <= i_vs;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Line A: registered read with read-first semantics, then store the new pixel
    always_ff @(posedge clk) begin
        if (i_de) begin
            a_rd_q          <= line_a[pos_col];
            line_a[pos_col] <= i_data;
        end
    end

    // Line B: the old A word is written one cycle later, once its registered
    // read is available. The same column is not read again until the next line.
    // The only exception is a resync that lands on that column, and row padding
    // hides that read.
    always_ff @(posedge clk) begin
        if (i_de) begin
            b_rd_q <= line_b[pos_col];
        end
        if (s1_de_q) begin
            line_b[s1_col_q] <= a_rd_q;
        end
    end

    // Stage 1: capture the pixel and its position alongside the buffer reads
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_de_q  <= 1'b0;
            s1_col_q <= '0;
            s1_row_q <= 2'd0;
            s1_pix_q <= '0;
        end else begin
            s1_de_q <= i_de;
            if (i_de) begin
                s1_col_q <= pos_col;
                s1_row_q <= pos_row;
                s1_pix_q <= i_data;
            end
        end
    end

    assign col_new[0] = b_rd_q;
    assign col_new[1] = a_rd_q;
    assign col_new[2] = s1_pix_q;

    // Padding masks, derived from the position of the newest pixel
    always_comb begin
        row_ok    = 3'b100;
        col_ok    = 3'b100;
        row_ok[0] = (s1_row_q == 2'd2);
        row_ok[1] = (s1_row_q != 2'd0);
        col_ok[0] = (s1_col_q >= CW'(2));
        col_ok[1] = (s1_col_q != '0);
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            logic [DW-1:0]         hist1_q;
            logic [DW-1:0]         hist2_q;
            logic [2:0][DW-1:0]    win_q;

            // Shift this row left by one column per pixel and pad the outputs
            always_ff @(posedge clk) begin
                if (rst) begin
                    hist1_q <= '0;
                    hist2_q <= '0;
                    win_q   <= '0;
                end else if (s1_de_q) begin
                    hist1_q  <= col_new[gi];
                    hist2_q  <= hist1_q;
                    win_q[0] <= (row_ok[gi] && col_ok[0]) ? hist2_q : '0;
                    win_q[1] <= (row_ok[gi] && col_ok[1]) ? hist1_q : '0;
                    win_q[2] <= row_ok[gi] ? col_new[gi] : '0;
                end
            end

            assign row_win[gi] = win_q;
        end
    endgenerate

    // Output sync and valid, two cycles behind the inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            o_vs_q <= 1'b0;
            o_de_q <= 1'b0;
        end else begin
            o_vs_q <= vs_q;
            o_de_q <= s1_de_q;
        end
    end

    assign o_vs  = o_vs_q;
    assign o_de  = o_de_q;
    assign o_p11 = row_win[0][DW-1:0];
    assign o_p12 = row_win[0][2*DW-1:DW];
    assign o_p13 = row_win[0][3*DW-1:2*DW];
    assign o_p21 = row_win[1][DW-1:0];
    assign o_p22 = row_win[1][2*DW-1:DW];
    assign o_p23 = row_win[1][3*DW-1:2*DW];
    assign o_p31 = row_win[2][DW-1:0];
    assign o_p32 = row_win[2][2*DW-1:DW];
    assign o_p33 = row_win[2][3*DW-1:2*DW];

endmodule

// File: tb/tb_median_matrix_3x3.sv
// Scoreboard bench for median_matrix_3x3 with IMG_WIDTH=4.
// The driver pushes the expected window for every accepted pixel. The monitor
// checks o_de, o_vs, each window, and the held outputs during gaps.
module tb_median_matrix_3x3;

    localparam int W  = 4;
    localparam int DW = 8;

    typedef logic [8:0][DW-1:0] win_t;   // [0]=p11 ... [8]=p33

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_vs = 1'b0;
    logic          i_de = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_vs, o_de;
    logic [DW-1:0] o_p11, o_p12, o_p13, o_p21, o_p22, o_p23, o_p31, o_p32, o_p33;

    median_matrix_3x3 #(.IMG_WIDTH(W), .DW(DW)) dut (
        .clk(clk), .rst(rst), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
        .o_vs(o_vs), .o_de(o_de),
        .o_p11(o_p11), .o_p12(o_p12), .o_p13(o_p13),
        .o_p21(o_p21), .o_p22(o_p22), .o_p23(o_p23),
        .o_p31(o_p31), .o_p32(o_p32), .o_p33(o_p33)
    );

    always #5 clk = ~clk;

    win_t          exp_q[$];
    logic [DW-1:0] img [0:7][0:W-1];
    int            tb_row = 0;
    int            tb_col = 0;
    bit            tb_vs_prev = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            win_cnt = 0;
    bit            mon_en = 1'b1;

    // Input history seen at each active edge
    logic [1:0] de_h = 2'b00;
    logic [1:0] vs_h = 2'b00;
    logic [1:0] rst_h = 2'b11;
    win_t       last_exp = '0;

    always @(posedge clk) begin
        de_h  <= {de_h[0], i_de};
        vs_h  <= {vs_h[0], i_vs};
        rst_h <= {rst_h[0], rst};
    end

    function automatic win_t dut_win();
        win_t w;
        w[0] = o_p11; w[1] = o_p12; w[2] = o_p13;
        w[3] = o_p21; w[4] = o_p22; w[5] = o_p23;
        w[6] = o_p31; w[7] = o_p32; w[8] = o_p33;
        return w;
    endfunction

    // Hand-computed windows from the first frame after reset (pixel index order)
    function automatic bit spot(input int idx, output win_t w);
        w = '0;
        case (idx)
            2:  begin w = {8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; return 1'b1; end
            8:  begin w = {8'h20, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; return 1'b1; end
            9:  begin w = {8'h21, 8'h20, 8'h00, 8'h11, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00}; return 1'b1; end
            10: begin w = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00}; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    // One input cycle; accepted pixels push their padded window
    task automatic step_cycle(input bit de, input bit vs, input logic [DW-1:0] v, input bit rs);
        win_t e;
        int   rr, cc;
        @(negedge clk);
        rst    = rs;
        i_de   = de;
        i_vs   = vs;
        i_data = v;
        if (rs) begin
            tb_row     = 0;
            tb_col     = 0;
            tb_vs_prev = 1'b0;
        end else begin
            if (vs && !tb_vs_prev) begin
                tb_row = 0;
                tb_col = 0;
            end
            tb_vs_prev = vs;
            if (de) begin
                img[tb_row][tb_col] = v;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        rr = tb_row - 2 + i;
                        cc = tb_col - 2 + j;
                        e[i*3+j] = (rr < 0 || cc < 0) ? '0 : img[rr][cc];
                    end
                end
                exp_q.push_back(e);
                if (tb_col == W - 1) begin
                    tb_col = 0;
                    if (tb_row < 7) tb_row++;
                end else begin
                    tb_col++;
                end
            end
        end
    endtask

    task automatic px(input logic [DW-1:0] v);
        step_cycle(1'b1, 1'b0, v, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step_cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic stream_row(input int row, input bit gapped);
        for (int c = 0; c < W; c++) begin
            px(DW'(16 * row + c));
            if (gapped) idle(1);
        end
    endtask

    // Monitor: checks every cycle and pops the scoreboard on each window
    always @(negedge clk) begin
        win_t got, e, s;
        bit   exp_de, exp_vs;
        if (mon_en) begin
            exp_de = !(rst_h[0] | rst_h[1]) && de_h[1];
            exp_vs = !(rst_h[0] | rst_h[1]) && vs_h[1];
            n_tests++;
            if (o_de !== exp_de) begin
                n_fail++;
                $display("[TB] FAIL o_de: got %b required %b at %0t", o_de, exp_de, $time);
            end
            n_tests++;
            if (o_vs !== exp_vs) begin
                n_fail++;
                $display("[TB] FAIL o_vs: got %b required %b at %0t", o_vs, exp_vs, $time);
            end
            if (rst_h[0]) last_exp = '0;
            got = dut_win();
            if (o_de === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL sb_empty: window %h with nothing expected", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("[TB] FAIL window #%0d: got %h required %h", win_cnt, got, e);
                    end else begin
                        $display("[TB] window #%0d ok %h", win_cnt, got);
                    end
                    if (spot(win_cnt, s)) begin
                        n_tests++;
                        if (got !== s) begin
                            n_fail++;
                            $display("[TB] FAIL spot #%0d: got %h required %h", win_cnt, got, s);
                        end
                    end
                    last_exp = e;
                    win_cnt++;
                end
            end else begin
                n_tests++;
                if (got !== last_exp) begin
                    n_fail++;
                    $display("[TB] FAIL hold: got %h required %h at %0t", got, last_exp, $time);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        // Reset held for three cycles with random inputs
        for (int k = 0; k < 3; k++)
            step_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom), 1'b1);
        // First frame straight after reset, no gaps, no sync pulse
        for (int r = 0; r < 3; r++) stream_row(r, 1'b0);
        idle(3);
        // Gapped frame, sync rising together with the first pixel
        step_cycle(1'b1, 1'b1, 8'h00, 1'b0);
        idle(1);
        for (int c = 1; c < W; c++) begin
            px(DW'(c));
            idle(1);
        end
        for (int r = 1; r < 3; r++) stream_row(r, 1'b1);
        idle(3);
        // Mid-frame resync after pixel (1,1) using a sync pulse
        step_cycle(1'b0, 1'b1, '0, 1'b0);
        step_cycle(1'b0, 1'b0, '0, 1'b0);
        stream_row(0, 1'b0);
        px(8'h10);
        px(8'h11);
        step_cycle(1'b0, 1'b1, '0, 1'b0);
        step_cycle(1'b0, 1'b0, '0, 1'b0);
        px(8'hA5);
        for (int c = 1; c < W; c++) px(DW'(c));
        stream_row(1, 1'b0);
        idle(3);
        // Same sequence with reset in place of the sync pulse
        stream_row(0, 1'b0);
        px(8'h10);
        px(8'h11);
        idle(3);
        step_cycle(1'b0, 1'b0, '0, 1'b1);
        px(8'hA5);
        for (int c = 1; c < W; c++) px(DW'(c));
        stream_row(1, 1'b0);
        // Drain the scoreboard within a bounded number of cycles
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            idle(1);
            wait_cyc++;
        end
        idle(2);
        mon_en = 1'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d windows outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
